vga_write_arbiter: RTL and testbench
====================================

// Module: vga_write_arbiter
// PURPOSE
//  Shares the single VGA adapter write port among NUM_REQ pixel producers (grid drawer, player drawer, raytracer
//  column drawer) using req/grant handshake with round-robin priority and a per-grant burst cap. Owns the
//  frame-rate limiter: writes pass only inside a per-frame write window. Replaces the static vga_access mux.
// PARAMETERS
//  NUM_REQ       3        number of requesters (index 0..NUM_REQ-1)
//  FRAME_PERIOD  1700000  clock cycles per frame (limiter period)
//  WINDOW_LEN    1000     cycles per frame in which VGA writes are allowed
//  MAX_BURST     64       max accepted writes per grant before forced hand-off
// PORTS
//  clock     in   1            system clock
//  reset     in   1            synchronous, active-high
//  req       in   NUM_REQ      level request, held while requester has pixels
//  req_x     in   8*NUM_REQ    packed x, requester i at [8i+7:8i]
//  req_y     in   7*NUM_REQ    packed y
//  req_col   in   18*NUM_REQ   packed colour
//  req_w     in   NUM_REQ      requester write strobe
//  grant     out  NUM_REQ      one-hot (or zero) grant
//  vga_x     out  8            registered pixel x
//  vga_y     out  7            registered pixel y
//  vga_colour out 18           registered colour
//  vga_write out  1            registered write enable
//  window_open out 1           write window active this cycle
//  frame_tick  out 1           one-cycle pulse at frame boundary
// BEHAVIOUR
//  Reset: grant=0, vga_x/y/colour=0, vga_write=0, state=IDLE, rr pointer=0 (req 0 highest), burst=0,
//   limiter=FRAME_PERIOD-1, frame_tick=0.
//  Limiter: decrements each cycle; at 0 reloads FRAME_PERIOD-1 and frame_tick=1 that cycle.
//   window_open = (limiter < WINDOW_LEN).
//  States: IDLE (no grant), OWN (grant[owner]=1), HANDOFF (grant=0, exactly one cycle).
//  IDLE: if window_open & |req -> OWN, owner = first set req at/after rr pointer (wrapping), grant next cycle.
//  OWN: accepted write = req_w[owner] & window_open; each increments burst (width clog2(MAX_BURST+1)).
//   req[owner] low -> HANDOFF. burst reaches MAX_BURST -> HANDOFF. window_open low -> IDLE (no HANDOFF).
//   Priority if simultaneous: window close > req drop > burst cap.
//  Leaving OWN: rr pointer = owner+1 mod NUM_REQ; burst=0; grant cleared same edge.
//  HANDOFF -> IDLE always; owner still requesting re-wins only if no other req is set.
//  Output path: vga_x/y/colour/write registered from owner's fields, 1-cycle latency after req_w.
//   vga_write=0 (x/y/colour=0) whenever not in OWN, window closed, or owner req_w low.
//  Writes from non-granted requesters are ignored; requesters must stall on grant=0 (window close mid-burst).
//  Reset mid-burst: all state to reset values next edge; no write emitted that cycle.
// CONFIGURATION
//  VGA_ARB_WINDOW_EN defined: window gating as above.
//  Not defined: window_open tied 1, grants/writes never gated by limiter; limiter and frame_tick still run.
// TESTING (FRAME_PERIOD=20, WINDOW_LEN=8, MAX_BURST=4, NUM_REQ=3, VGA_ARB_WINDOW_EN defined)
//  Reset then idle -> grant=0, vga_write=0; frame_tick every 20 cycles; window_open 8 of each 20.
//  req=3'b001, req_w[0]=1 x=5 y=7 in window -> grant=001 next cycle, vga_x=5 vga_y=7 vga_write=1 one cycle later.
//  req=3'b111 held, req_w all 1 -> grant order 001,010,100,001; 4 writes each, 1 HANDOFF cycle between.
//  req=3'b001 only, 6 writes -> 4 writes, 1 HANDOFF cycle with grant=0, re-grant 001, 2 more writes.
//  Grant held as window closes -> grant=0 and vga_write=0 first closed cycle; re-grant at next window.
//  req_w[2]=1 while grant=001 -> requester 2 fields never appear on vga_*.
//  Macro undefined, req=3'b010 held -> writes continue across limiter cycles 8..19 without gap.

Source files
------------

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter for the VGA adapter write port, with a per-frame write window.
// Define VGA_ARB_WINDOW_EN to gate grants and writes with the frame limiter window.
module vga_write_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int FRAME_PERIOD = 1700000,
  parameter int WINDOW_LEN   = 1000,
  parameter int MAX_BURST    = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [8*NUM_REQ-1:0]    req_x,
  input  logic [7*NUM_REQ-1:0]    req_y,
  input  logic [18*NUM_REQ-1:0]   req_col,
  input  logic [NUM_REQ-1:0]      req_w,
  output logic [NUM_REQ-1:0]      grant,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [17:0]             vga_colour,
  output logic                    vga_write,
  output logic                    window_open,
  output logic                    frame_tick
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int LW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_OWN     = 2'd1;
  localparam logic [1:0] S_HANDOFF = 2'd2;

  localparam logic [LW-1:0] LIM_TOP   = LW'(FRAME_PERIOD - 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);
  localparam logic [OW-1:0] LAST_REQ  = OW'(NUM_REQ - 1);
  localparam logic [31:0]   WIN_LEN   = 32'(WINDOW_LEN);

  if (NUM_REQ < 1) begin : g_bad_num_req
    $error("NUM_REQ must be at least 1");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end
  if (WINDOW_LEN < 1 || WINDOW_LEN > FRAME_PERIOD) begin : g_bad_window
    $error("WINDOW_LEN must lie in 1..FRAME_PERIOD");
  end

  logic [LW-1:0] limiter;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [OW-1:0] owner;
  logic [OW-1:0] owner_nx;
  logic [OW-1:0] owner_wrap;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] rr_nx;
  logic [BW-1:0] burst;
  logic [BW-1:0] burst_nx;
  logic [BW-1:0] burst_inc;

  logic          owning;
  logic          accept;
  logic          own_req;
  logic          own_w;
  logic [7:0]    own_x;
  logic [6:0]    own_y;
  logic [17:0]   own_col;

  logic          pick_found;
  logic [OW-1:0] pick;

  // Limiter counts down; the zero cycle is the frame boundary.
  assign frame_tick = (limiter == '0);

`ifdef VGA_ARB_WINDOW_EN
  assign window_open = (32'(limiter) < WIN_LEN);
`else
  assign window_open = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      limiter <= LIM_TOP;
    end else if (frame_tick) begin
      limiter <= LIM_TOP;
    end else begin
      limiter <= limiter - 1'b1;
    end
  end

  always_comb begin
    own_req = 1'b0;
    own_w   = 1'b0;
    own_x   = '0;
    own_y   = '0;
    own_col = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OW'(i)) begin
        own_req = req[i];
        own_w   = req_w[i];
        own_x   = req_x[8*i +: 8];
        own_y   = req_y[7*i +: 7];
        own_col = req_col[18*i +: 18];
      end
    end
  end

  // Grant drops in the first closed cycle, before the FSM reaches IDLE.
  assign owning = (state == S_OWN) && window_open;
  assign accept = owning && own_w;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owning && owner == OW'(i)) begin
        grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    int cand;
    cand       = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!pick_found && req[OW'(cand)]) begin
        pick_found = 1'b1;
        pick       = OW'(cand);
      end
    end
  end

  assign owner_wrap = (owner == LAST_REQ) ? '0 : owner + 1'b1;
  assign burst_inc  = burst + BW'(accept);

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr_ptr;
    burst_nx = burst;
    unique case (state)
      S_IDLE: begin
        if (window_open && pick_found) begin
          state_nx = S_OWN;
          owner_nx = pick;
        end
      end
      S_OWN: begin
        burst_nx = burst_inc;
        if (!window_open) begin
          state_nx = S_IDLE;
          rr_nx    = owner_wrap;
          burst_nx = '0;
        end else if (!own_req || burst_inc == BURST_CAP) begin
          state_nx = S_HANDOFF;
          rr_nx    = owner_wrap;
          burst_nx = '0;
        end
      end
      S_HANDOFF: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        burst_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      burst  <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_nx;
      burst  <= burst_nx;
    end
  end

  // Fields are zeroed whenever no write is emitted.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_write  <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      vga_write  <= accept;
      vga_x      <= accept ? own_x : '0;
      vga_y      <= accept ? own_y : '0;
      vga_colour <= accept ? own_col : '0;
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter at FRAME_PERIOD=20, WINDOW_LEN=8, MAX_BURST=4.
// Expectations follow VGA_ARB_WINDOW_EN as seen by this compile.
module tb_vga_write_arbiter;

`ifdef VGA_ARB_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [53:0] req_col;
  logic [2:0]  req_w;
  logic [2:0]  grant;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [17:0] vga_colour;
  logic        vga_write;
  logic        window_open;
  logic        frame_tick;

  int vecs;
  int fails;

  vga_write_arbiter #(
    .NUM_REQ(3),
    .FRAME_PERIOD(20),
    .WINDOW_LEN(8),
    .MAX_BURST(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .req_x(req_x),
    .req_y(req_y),
    .req_col(req_col),
    .req_w(req_w),
    .grant(grant),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .vga_colour(vga_colour),
    .vga_write(vga_write),
    .window_open(window_open),
    .frame_tick(frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] r;
    logic [2:0] w;
    logic [7:0] x;
    logic [2:0] g;
    logic       wr;
    logic [7:0] vx;
    logic       win;
    logic       tick;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] rr_x(input logic [2:0] g);
    logic [7:0] v;
    v = 8'h00;
    if (g == 3'b001) v = 8'h40;
    if (g == 3'b010) v = 8'h41;
    if (g == 3'b100) v = 8'h42;
    return v;
  endfunction

  initial begin
    int n_all;
    int n_early;
    int bad;
    int n_ok;
    int nruns;
    int nend;
    int t1;
    int t2;
    int wcnt;
    bit found;
    logic [2:0] prev_g;
    logic [2:0] rv[4];
    int rlen[4];
    int rstart[4];
    int rend[4];
    int exp_len[4];

    vecs  = 0;
    fails = 0;
    reset = 1'b0;
    req   = '0;
    req_w = '0;
    req_x = '0;
    req_y = '0;
    req_col = '0;

    // cycle numbers are counted from the first cycle after reset release
    tbl[0]  = '{3'b001, 3'b001, 8'd5,  3'b000, 1'b0, 8'd0,  1'b1, 1'b0};
    tbl[1]  = '{3'b001, 3'b001, 8'd6,  3'b001, 1'b0, 8'd0,  1'b1, 1'b0};
    tbl[2]  = '{3'b001, 3'b001, 8'd7,  3'b001, 1'b1, 8'd6,  1'b1, 1'b0};
    tbl[3]  = '{3'b001, 3'b001, 8'd8,  3'b001, 1'b1, 8'd7,  1'b1, 1'b0};
    tbl[4]  = '{3'b001, 3'b001, 8'd9,  3'b001, 1'b1, 8'd8,  1'b1, 1'b0};
    tbl[5]  = '{3'b001, 3'b001, 8'd10, 3'b000, 1'b1, 8'd9,  1'b1, 1'b0};
    tbl[6]  = '{3'b001, 3'b001, 8'd11, 3'b000, 1'b0, 8'd0,  1'b1, 1'b0};
    tbl[7]  = '{3'b001, 3'b001, 8'd12, 3'b001, 1'b0, 8'd0,  1'b1, 1'b1};
    if (WIN_EN) begin
      tbl[8]  = '{3'b001, 3'b001, 8'd13, 3'b000, 1'b1, 8'd12, 1'b0, 1'b0};
      tbl[9]  = '{3'b000, 3'b000, 8'd14, 3'b000, 1'b0, 8'd0,  1'b0, 1'b0};
      tbl[10] = '{3'b000, 3'b000, 8'd15, 3'b000, 1'b0, 8'd0,  1'b0, 1'b0};
    end else begin
      tbl[8]  = '{3'b001, 3'b001, 8'd13, 3'b001, 1'b1, 8'd12, 1'b1, 1'b0};
      tbl[9]  = '{3'b000, 3'b000, 8'd14, 3'b001, 1'b1, 8'd13, 1'b1, 1'b0};
      tbl[10] = '{3'b000, 3'b000, 8'd15, 3'b000, 1'b0, 8'd0,  1'b1, 1'b0};
    end

    // reset state and idle cycles 0..11
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      chk($sformatf("idle%0d grant", c), 32'(grant), 32'd0);
      chk($sformatf("idle%0d write", c), 32'(vga_write), 32'd0);
      chk($sformatf("idle%0d tick", c), 32'(frame_tick), 32'd0);
      chk($sformatf("idle%0d win", c), 32'(window_open), 32'(!WIN_EN));
      if (c == 0) begin
        chk("reset vga_x", 32'(vga_x), 32'd0);
        chk("reset vga_colour", 32'(vga_colour), 32'd0);
      end
      next_cycle();
    end

    // table: cycles 12..22, requester 0 bursting through a handoff
    req_y[6:0]   = 7'd7;
    req_col[17:0] = 18'h2AAAA;
    req_x[15:8]  = 8'hB1;
    req_x[23:16] = 8'hC2;
    for (int k = 0; k < 11; k++) begin
      req   = tbl[k].r;
      req_w = tbl[k].w;
      req_x[7:0] = tbl[k].x;
      @(negedge clock);
      chk($sformatf("tbl%0d grant", k), 32'(grant), 32'(tbl[k].g));
      chk($sformatf("tbl%0d write", k), 32'(vga_write), 32'(tbl[k].wr));
      chk($sformatf("tbl%0d vga_x", k), 32'(vga_x), 32'(tbl[k].vx));
      chk($sformatf("tbl%0d vga_y", k), 32'(vga_y),
          tbl[k].wr ? 32'd7 : 32'd0);
      chk($sformatf("tbl%0d colour", k), 32'(vga_colour),
          tbl[k].wr ? 32'h2AAAA : 32'd0);
      chk($sformatf("tbl%0d win", k), 32'(window_open), 32'(tbl[k].win));
      chk($sformatf("tbl%0d tick", k), 32'(frame_tick), 32'(tbl[k].tick));
      next_cycle();
    end

    // requester 1 alone: writes keep coming while the limiter is high
    req = '0;
    req_w = '0;
    do_reset();
    req = 3'b010;
    req_w = 3'b010;
    req_x[15:8] = 8'h33;
    n_all = 0;
    n_early = 0;
    bad = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (vga_write) begin
        n_all++;
        if (c < 12) n_early++;
        if (vga_x != 8'h33) bad++;
      end
      next_cycle();
    end
    chk("solo writes c0-11", 32'(n_early), WIN_EN ? 32'd0 : 32'd8);
    chk("solo writes c0-23", 32'(n_all), WIN_EN ? 32'd5 : 32'd16);
    chk("solo wrong x", 32'(bad), 32'd0);

    // requester 2 strobes without requesting: never reaches the port
    req = '0;
    req_w = '0;
    do_reset();
    req = 3'b001;
    req_w = 3'b101;
    req_x = {8'h22, 8'h00, 8'h11};
    n_ok = 0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (vga_write) begin
        if (vga_x == 8'h11) n_ok++;
        else bad++;
      end
      next_cycle();
    end
    chk("req0 writes", 32'(n_ok), WIN_EN ? 32'd5 : 32'd20);
    chk("req2 leaked", 32'(bad), 32'd0);

    // all three requesting: round-robin order and burst lengths
    req = '0;
    req_w = '0;
    do_reset();
    req = 3'b111;
    req_w = 3'b111;
    req_x = {8'h42, 8'h41, 8'h40};
    req_y = {7'd3, 7'd2, 7'd1};
    prev_g = '0;
    nruns = 0;
    nend = 0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      rv[k] = '0;
      rlen[k] = 0;
      rstart[k] = 0;
      rend[k] = 0;
    end
    for (int c = 0; c < 200 && nend < 4; c++) begin
      @(negedge clock);
      if (!$onehot0(grant)) bad++;
      if (vga_write) begin
        if (prev_g == 3'b000 || vga_x != rr_x(prev_g)) bad++;
      end else if (vga_x != 8'h00) begin
        bad++;
      end
      if (grant != prev_g) begin
        if (prev_g != 3'b000 && nend < 4) begin
          rend[nend] = c - 1;
          rlen[nend] = c - rstart[nend];
          nend++;
        end
        if (grant != 3'b000 && nruns < 4) begin
          rv[nruns] = grant;
          rstart[nruns] = c;
          nruns++;
        end
      end
      prev_g = grant;
      next_cycle();
    end
    exp_len = WIN_EN ? '{4, 1, 4, 1} : '{4, 4, 4, 4};
    chk("rr runs seen", 32'(nend), 32'd4);
    chk("rr grant 0", 32'(rv[0]), 32'b001);
    chk("rr grant 1", 32'(rv[1]), 32'b010);
    chk("rr grant 2", 32'(rv[2]), 32'b100);
    chk("rr grant 3", 32'(rv[3]), 32'b001);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr len %0d", k), 32'(rlen[k]), 32'(exp_len[k]));
    end
    chk("rr gap", 32'(rstart[1] - rend[0]), 32'd3);
    chk("rr bad cycles", 32'(bad), 32'd0);

    // reset while a write is in flight
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clock);
      if (vga_write) found = 1'b1;
      else next_cycle();
    end
    chk("midburst write seen", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    req = '0;
    req_w = '0;
    t1 = -1;
    t2 = -1;
    wcnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clock);
      if (c == 0) begin
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst write", 32'(vga_write), 32'd0);
        chk("rst vga_x", 32'(vga_x), 32'd0);
        chk("rst tick", 32'(frame_tick), 32'd0);
      end
      if (frame_tick) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
      if (c >= 20 && c < 40 && window_open) wcnt++;
      next_cycle();
    end
    chk("first tick", 32'(t1), 32'd19);
    chk("second tick", 32'(t2), 32'd39);
    chk("window cycles", 32'(wcnt), WIN_EN ? 32'd8 : 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
